dma_sync_fifo: RTL and testbench
================================

# dma_sync_fifo

Parametrised single-clock FIFO for the DMA controller's read-to-write data path, buffering AXI4-Lite read-channel data until the write channel drains it. It has correct full detection at every depth, an occupancy count, programmable almost-full and almost-empty thresholds, and a selectable standard or first-word-fall-through (FWFT) read mode. Sticky overflow and underflow error flags report protocol misuse to the DMA status register.

## Interface
- DATA_WIDTH, 32, word width in bits.
- DEPTH, 16, number of entries; power of two, at least 2.
- FWFT, 0, read mode: 0 = registered read on pop, 1 = head word presented combinationally.
- AF_LEVEL, DEPTH-2, almost_full asserts when count >= AF_LEVEL.
- AE_LEVEL, 2, almost_empty asserts when count <= AE_LEVEL.

Ports. Reset rst_n is synchronous and active-low; clock is clk.
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  synchronous active-low reset.
- w_en  in  1  push request.
- r_en  in  1  pop request.
- data_in  in  DATA_WIDTH  push data.
- err_clr  in  1  clears overflow and underflow (synchronous).
- data_out  out  DATA_WIDTH  read data.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count >= AF_LEVEL.
- almost_empty  out  1  count <= AE_LEVEL.
- count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- overflow  out  1  sticky: a push was attempted while full.
- underflow  out  1  sticky: a pop was attempted while empty.

## Operation
- Write and read pointers are $clog2(DEPTH)+1 bits wide. The low bits index storage; the MSB is a wrap bit.
- empty: pointers are equal.
- full: MSBs differ and the low bits are equal.
- count = w_ptr - r_ptr, computed modulo 2^(AW+1).
- A push is accepted when w_en && !full: it writes mem[w_ptr] and increments w_ptr.
- A pop is accepted when r_en && !empty: it increments r_ptr.
- full and empty are judged on the current-cycle state:
  - w_en && r_en while full: the pop is accepted, the push is rejected, and overflow is set.
  - w_en && r_en while empty: the push is accepted, the pop is rejected, and underflow is set.
  - w_en && r_en otherwise: both are accepted and count is unchanged.
- Pointers wrap naturally. No entry is lost or duplicated across the wrap.
- overflow and underflow set on a rejected request. They clear only on reset or err_clr; if set and clear happen in the same cycle, set wins.
- FWFT=0: data_out is a register. It loads mem[r_ptr] on an accepted pop and holds its value otherwise.
- FWFT=1: data_out = mem[r_ptr[AW-1:0]] combinationally. It is valid whenever !empty and don't-care when empty; r_en acknowledges the head word.
- Storage is not reset.
- Reset: pointers = 0, data_out = 0 (FWFT=0 only), overflow = 0, underflow = 0. This gives empty=1, full=0, count=0, almost_empty=1, and almost_full=0 (for AF_LEVEL>0).
- Reset mid-operation discards all contents immediately and overrides w_en and r_en in that cycle.

## Timing
- All flags and count derive combinationally from registered pointers, so they update one cycle after the accepting edge.
- Push at edge N: the word is visible from edge N (empty deasserts and count increments after edge N).
  - FWFT=0: a pop at edge N+1 makes data_out show the word after edge N+1 (1-cycle read latency).
  - FWFT=1: data_out shows the word after edge N (0-cycle read latency).
- Error flags assert on the edge following the rejected request.
- No combinational path exists from w_en or r_en to any output.

## Test plan
- Reset, then push 0x00..0x0F (16 words): full=1 and count=16 after the 16th push. A 17th push of 0xAA is ignored and overflow=1. Then pop 16 words: data_out is 0x00..0x0F in order, then empty=1.
- Wrap: 3 rounds of push 10 / pop 10 with incrementing data → no loss, no reordering, count returns to 0 each round.
- Full plus simultaneous push and pop: count stays at 15 after the edge, the pushed word is not stored, and overflow=1. err_clr → overflow=0.
- Empty plus simultaneous push and pop: count=1 after the edge and underflow=1.
- Thresholds at AF_LEVEL=14, AE_LEVEL=2: almost_empty falls at count=3 and almost_full rises at count=14.
- FWFT=1: push 0x1234 → data_out=0x1234 the next cycle with no pop. Pop → empty=1. Reset at count=9 → count=0, empty=1.

Source files
------------

// File: rtl/dma_sync_fifo.sv
// dma_sync_fifo: single-clock FIFO buffering DMA read-channel data until the
// write channel drains it. Provides occupancy count, programmable almost-full /
// almost-empty thresholds, standard or first-word-fall-through read mode, and
// sticky overflow / underflow error flags.
//
// Ports:
//   clk          clock, all state updates on the rising edge
//   rst_n        synchronous active-low reset
//   w_en, r_en   push / pop requests
//   data_in      push data
//   err_clr      clears overflow and underflow
//   data_out     read data (registered on pop, or head word when FWFT=1)
//   full, empty, almost_full, almost_empty, count   occupancy status
//   overflow     sticky: push attempted while full
//   underflow    sticky: pop attempted while empty
module dma_sync_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16,
  parameter int FWFT       = 0,
  parameter int AF_LEVEL   = DEPTH - 2,
  parameter int AE_LEVEL   = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    w_en,
  input  logic                    r_en,
  input  logic [DATA_WIDTH-1:0]   data_in,
  input  logic                    err_clr,
  output logic [DATA_WIDTH-1:0]   data_out,
  output logic                    full,
  output logic                    empty,
  output logic                    almost_full,
  output logic                    almost_empty,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    overflow,
  output logic                    underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] AF_THR = (AW+1)'(AF_LEVEL);
  localparam logic [AW:0] AE_THR = (AW+1)'(AE_LEVEL);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW:0]           w_ptr;
  logic [AW:0]           r_ptr;
  logic                  push;
  logic                  pop;

  // Extra wrap bit distinguishes full from empty when the index bits match.
  always_comb begin
    empty        = (w_ptr == r_ptr);
    full         = (w_ptr[AW] != r_ptr[AW]) && (w_ptr[AW-1:0] == r_ptr[AW-1:0]);
    count        = w_ptr - r_ptr;
    almost_full  = (count >= AF_THR);
    almost_empty = (count <= AE_THR);
    push         = w_en && !full;
    pop          = r_en && !empty;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      w_ptr <= '0;
      r_ptr <= '0;
    end else begin
      if (push) w_ptr <= w_ptr + 1'b1;
      if (pop)  r_ptr <= r_ptr + 1'b1;
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (rst_n && push) mem[w_ptr[AW-1:0]] <= data_in;
  end

  // Set has priority over clear so an error in the clearing cycle is not lost.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (w_en && full)  overflow <= 1'b1;
      else if (err_clr)  overflow <= 1'b0;
      if (r_en && empty) underflow <= 1'b1;
      else if (err_clr)  underflow <= 1'b0;
    end
  end

  if (FWFT != 0) begin : g_fwft
    assign data_out = mem[r_ptr[AW-1:0]];
  end else begin : g_reg
    always_ff @(posedge clk) begin
      if (!rst_n)   data_out <= '0;
      else if (pop) data_out <= mem[r_ptr[AW-1:0]];
    end
  end

endmodule

// File: tb/tb_dma_sync_fifo.sv
// Self-checking bench for dma_sync_fifo: a standard-mode instance driven by a
// queue-based reference model plus a vector table, and an FWFT instance driven
// by a short hand-written sequence.
module tb_dma_sync_fifo;

  logic        clk;
  // standard-mode instance
  logic        rst0, w0, r0, clr0;
  logic [31:0] d0, dout0;
  logic        full0, empty0, af0, ae0, ovf0, unf0;
  logic [4:0]  cnt0;
  // FWFT instance
  logic        rst1, w1, r1, clr1;
  logic [31:0] d1, dout1;
  logic        full1, empty1, af1, ae1, ovf1, unf1;
  logic [4:0]  cnt1;

  int checks = 0;
  int errors = 0;

  logic [31:0] q[$];
  logic [31:0] m_dout;
  logic        m_ovf, m_unf;

  typedef struct {
    logic        w, r, clr;
    logic [31:0] d;
    logic [31:0] e_cnt;
    logic        e_empty, e_ovf, e_unf;
    logic [31:0] e_dout;
  } vec_t;
  vec_t tbl[10];

  dma_sync_fifo #(.DATA_WIDTH(32), .DEPTH(16), .FWFT(0), .AF_LEVEL(14), .AE_LEVEL(2)) dut0 (
    .clk(clk), .rst_n(rst0), .w_en(w0), .r_en(r0), .data_in(d0), .err_clr(clr0),
    .data_out(dout0), .full(full0), .empty(empty0), .almost_full(af0),
    .almost_empty(ae0), .count(cnt0), .overflow(ovf0), .underflow(unf0));

  dma_sync_fifo #(.DATA_WIDTH(32), .DEPTH(16), .FWFT(1), .AF_LEVEL(14), .AE_LEVEL(2)) dut1 (
    .clk(clk), .rst_n(rst1), .w_en(w1), .r_en(r1), .data_in(d1), .err_clr(clr1),
    .data_out(dout1), .full(full1), .empty(empty1), .almost_full(af1),
    .almost_empty(ae1), .count(cnt1), .overflow(ovf1), .underflow(unf1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_check();
    int n;
    n = q.size();
    chk("count", 32'(cnt0), 32'(n));
    chk("full", 32'(full0), 32'(n == 16));
    chk("empty", 32'(empty0), 32'(n == 0));
    chk("almost_full", 32'(af0), 32'(n >= 14));
    chk("almost_empty", 32'(ae0), 32'(n <= 2));
    chk("overflow", 32'(ovf0), 32'(m_ovf));
    chk("underflow", 32'(unf0), 32'(m_unf));
    chk("data_out", dout0, m_dout);
  endtask

  // One clock of stimulus on the standard instance; expected data is queued on
  // push and popped from the scoreboard when the DUT should present it.
  task automatic cyc(input logic w, input logic r, input logic clr, input logic [31:0] d);
    int n;
    n = q.size();
    w0 = w; r0 = r; clr0 = clr; d0 = d;
    if (w && n == 16) m_ovf = 1'b1; else if (clr) m_ovf = 1'b0;
    if (r && n == 0)  m_unf = 1'b1; else if (clr) m_unf = 1'b0;
    if (r && n != 0)  m_dout = q.pop_front();
    if (w && n != 16) q.push_back(d);
    @(posedge clk); #1;
    w0 = 1'b0; r0 = 1'b0; clr0 = 1'b0;
    model_check();
  endtask

  task automatic do_reset();
    rst0 = 1'b0; w0 = 1'b1; r0 = 1'b1; d0 = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    rst0 = 1'b1; w0 = 1'b0; r0 = 1'b0;
    q.delete();
    m_dout = '0; m_ovf = 1'b0; m_unf = 1'b0;
    chk("rst_count", 32'(cnt0), 32'd0);
    chk("rst_empty", 32'(empty0), 32'd1);
    chk("rst_full", 32'(full0), 32'd0);
    chk("rst_ae", 32'(ae0), 32'd1);
    chk("rst_af", 32'(af0), 32'd0);
    chk("rst_ovf", 32'(ovf0), 32'd0);
    chk("rst_unf", 32'(unf0), 32'd0);
    chk("rst_dout", dout0, 32'd0);
  endtask

  initial begin
    tbl[0] = '{1'b0, 1'b1, 1'b0, 32'h00, 32'd0, 1'b1, 1'b0, 1'b1, 32'h00};
    tbl[1] = '{1'b0, 1'b0, 1'b1, 32'h00, 32'd0, 1'b1, 1'b0, 1'b0, 32'h00};
    tbl[2] = '{1'b1, 1'b1, 1'b0, 32'h11, 32'd1, 1'b0, 1'b0, 1'b1, 32'h00};
    tbl[3] = '{1'b1, 1'b0, 1'b1, 32'h22, 32'd2, 1'b0, 1'b0, 1'b0, 32'h00};
    tbl[4] = '{1'b1, 1'b1, 1'b0, 32'h33, 32'd2, 1'b0, 1'b0, 1'b0, 32'h11};
    tbl[5] = '{1'b0, 1'b1, 1'b0, 32'h00, 32'd1, 1'b0, 1'b0, 1'b0, 32'h22};
    tbl[6] = '{1'b0, 1'b1, 1'b0, 32'h00, 32'd0, 1'b1, 1'b0, 1'b0, 32'h33};
    tbl[7] = '{1'b0, 1'b1, 1'b1, 32'h00, 32'd0, 1'b1, 1'b0, 1'b1, 32'h33};
    tbl[8] = '{1'b0, 1'b0, 1'b1, 32'h00, 32'd0, 1'b1, 1'b0, 1'b0, 32'h33};
    tbl[9] = '{1'b0, 1'b0, 1'b0, 32'h00, 32'd0, 1'b1, 1'b0, 1'b0, 32'h33};

    rst0 = 1'b1; w0 = 1'b0; r0 = 1'b0; clr0 = 1'b0; d0 = '0;
    rst1 = 1'b1; w1 = 1'b0; r1 = 1'b0; clr1 = 1'b0; d1 = '0;
    m_dout = '0; m_ovf = 1'b0; m_unf = 1'b0;

    // Fill, overflow, drain in order
    do_reset();
    for (int i = 0; i < 16; i++) cyc(1'b1, 1'b0, 1'b0, 32'(i));
    chk("fill_full", 32'(full0), 32'd1);
    chk("fill_count", 32'(cnt0), 32'd16);
    cyc(1'b1, 1'b0, 1'b0, 32'hAA);
    chk("ovf_set", 32'(ovf0), 32'd1);
    for (int i = 0; i < 16; i++) begin
      cyc(1'b0, 1'b1, 1'b0, 32'h0);
      chk("drain_word", dout0, 32'(i));
    end
    chk("drain_empty", 32'(empty0), 32'd1);
    cyc(1'b0, 1'b0, 1'b1, 32'h0);

    // Pointer wrap
    for (int rnd = 0; rnd < 3; rnd++) begin
      for (int i = 0; i < 10; i++) cyc(1'b1, 1'b0, 1'b0, 32'(32'h40 + rnd * 10 + i));
      for (int i = 0; i < 10; i++) cyc(1'b0, 1'b1, 1'b0, 32'h0);
      chk("wrap_count", 32'(cnt0), 32'd0);
    end

    // Simultaneous push/pop while full
    for (int i = 0; i < 16; i++) cyc(1'b1, 1'b0, 1'b0, 32'(32'h80 + i));
    cyc(1'b1, 1'b1, 1'b0, 32'hEE);
    chk("full_rw_count", 32'(cnt0), 32'd15);
    chk("full_rw_ovf", 32'(ovf0), 32'd1);
    cyc(1'b0, 1'b0, 1'b1, 32'h0);
    chk("ovf_clr", 32'(ovf0), 32'd0);
    for (int i = 0; i < 15; i++) cyc(1'b0, 1'b1, 1'b0, 32'h0);
    chk("full_rw_last", dout0, 32'h8F);

    // Simultaneous push/pop while empty
    cyc(1'b1, 1'b1, 1'b0, 32'h55);
    chk("empty_rw_count", 32'(cnt0), 32'd1);
    chk("empty_rw_unf", 32'(unf0), 32'd1);
    cyc(1'b0, 1'b1, 1'b1, 32'h0);
    chk("empty_rw_word", dout0, 32'h55);

    // Threshold edges
    for (int i = 1; i <= 16; i++) begin
      cyc(1'b1, 1'b0, 1'b0, 32'(32'hC0 + i));
      if (i == 2)  chk("ae_at_2", 32'(ae0), 32'd1);
      if (i == 3)  chk("ae_at_3", 32'(ae0), 32'd0);
      if (i == 13) chk("af_at_13", 32'(af0), 32'd0);
      if (i == 14) chk("af_at_14", 32'(af0), 32'd1);
    end
    for (int i = 0; i < 16; i++) cyc(1'b0, 1'b1, 1'b0, 32'h0);

    // Vector table from a fresh reset
    do_reset();
    for (int i = 0; i < 10; i++) begin
      cyc(tbl[i].w, tbl[i].r, tbl[i].clr, tbl[i].d);
      chk("tbl_count", 32'(cnt0), tbl[i].e_cnt);
      chk("tbl_empty", 32'(empty0), 32'(tbl[i].e_empty));
      chk("tbl_ovf", 32'(ovf0), 32'(tbl[i].e_ovf));
      chk("tbl_unf", 32'(unf0), 32'(tbl[i].e_unf));
      chk("tbl_dout", dout0, tbl[i].e_dout);
    end

    // FWFT instance
    rst1 = 1'b0; w1 = 1'b1;
    @(posedge clk); #1;
    rst1 = 1'b1; w1 = 1'b0;
    chk("fwft_rst_count", 32'(cnt1), 32'd0);
    chk("fwft_rst_empty", 32'(empty1), 32'd1);
    w1 = 1'b1; d1 = 32'h1234;
    @(posedge clk); #1;
    w1 = 1'b0;
    chk("fwft_head", dout1, 32'h1234);
    chk("fwft_count1", 32'(cnt1), 32'd1);
    @(posedge clk); #1;
    chk("fwft_hold", dout1, 32'h1234);
    r1 = 1'b1;
    @(posedge clk); #1;
    r1 = 1'b0;
    chk("fwft_pop_empty", 32'(empty1), 32'd1);
    for (int i = 0; i < 10; i++) begin
      w1 = 1'b1; d1 = 32'(32'h100 + i);
      @(posedge clk); #1;
    end
    w1 = 1'b0;
    chk("fwft_head0", dout1, 32'h100);
    r1 = 1'b1;
    @(posedge clk); #1;
    r1 = 1'b0;
    chk("fwft_head1", dout1, 32'h101);
    chk("fwft_count9", 32'(cnt1), 32'd9);
    rst1 = 1'b0; w1 = 1'b1; d1 = 32'hFF;
    @(posedge clk); #1;
    rst1 = 1'b1; w1 = 1'b0;
    chk("fwft_mid_rst_count", 32'(cnt1), 32'd0);
    chk("fwft_mid_rst_empty", 32'(empty1), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
